// File: rtl/apb_uart_pkg.sv
// apb_uart shared definitions
// register map, control/status bit positions, FSM states
package apb_uart_pkg;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_TXDATA = 5'd2;
  localparam logic [4:0] REG_RXDATA = 5'd3;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_TX_RST = 2;
  localparam int CTRL_RX_RST = 3;

  localparam int ST_RX_DONE   = 0;
  localparam int ST_TX_BUSY   = 1;
  localparam int ST_TX_DONE   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_OVERRUN   = 4;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// apb_uart receiver
// rx synchronizer, mid-bit sampling FSM and sticky receive status
module uart_rx
  import apb_uart_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CPB = 100
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          rd_i,
  input  logic          rx_i,
  output logic [DW-1:0] data_o,
  output logic          done_o,
  output logic          ferr_o,
  output logic          ovr_o
);

  localparam int CW = $clog2(CPB);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          rx_s;
  logic          fall;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  // two-flop synchronizer plus edge-detect history, idle high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx_s;
    end
  end

  // receiver state and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // next-state: start validation, mid-bit sampling, frame completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = done_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (rd_i) done_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (en_i && fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DW-1:1]};
          if (bit_q == BIT_LAST) state_d = RX_STOP;
          else bit_d = bit_q + BW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          data_d  = shift_q;
          done_d  = 1'b1;
          ferr_d  = ~rx_s;
          if (done_q && !rd_i) ovr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (!en_i) state_d = RX_IDLE;
    if (clr_i) begin
      state_d = RX_IDLE;
      cnt_d   = '0;
      data_d  = '0;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign data_o = data_q;
  assign done_o = done_q;
  assign ferr_o = ferr_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/apb_uart.sv
// apb_uart top level
// APB register file, 8N1 transmitter and receiver instance
module apb_uart
  import apb_uart_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 1_000_000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx,
  output logic        tx
);

  localparam int DW  = DATAWIDTH;
  localparam int CPR = CLK_FREQ / BAUD_RATE;
  localparam int CPB = (CPR < 4) ? 4 : CPR;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  logic [4:0]    idx;
  logic          wr, wr_ctrl, wr_tx;
  logic          tx_rst, rx_rst, rx_rd;
  logic          tx_en_q, rx_en_q;
  logic [DW-1:0] txdata_q;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [DW-1:0] tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_busy;
  logic [DW-1:0] rx_data;
  logic          rx_done, rx_ferr, rx_ovr;
  logic          unused;

  assign idx     = PADDR[4:0];
  assign wr      = PSEL & PENABLE & PWRITE;
  assign wr_ctrl = wr && (idx == REG_CTRL);
  assign wr_tx   = wr && (idx == REG_TXDATA);
  assign tx_rst  = wr_ctrl & PWDATA[CTRL_TX_RST];
  assign rx_rst  = wr_ctrl & PWDATA[CTRL_RX_RST];
  assign rx_rd   = PSEL & PENABLE & ~PWRITE
                 & (idx == REG_RXDATA);
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign PREADY  = 1'b1;
  assign tx      = tx_q;
  assign unused  = ^{PADDR[31:5], PWDATA[31:DW]};

  // software-visible control and TX data registers
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      tx_en_q  <= 1'b0;
      rx_en_q  <= 1'b0;
      txdata_q <= '0;
    end else begin
      if (wr_ctrl) begin
        tx_en_q <= PWDATA[CTRL_TX_EN];
        rx_en_q <= PWDATA[CTRL_RX_EN];
      end
      if (wr_tx) txdata_q <= PWDATA[DW-1:0];
    end
  end

  // transmitter state register
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // transmitter next-state: frame sequencing, abort and reset
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;
    if (wr_tx) tx_done_d = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (wr_tx && tx_en_q) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_sh_d    = PWDATA[DW-1:0];
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_MAX) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_MAX) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + BW'(1);
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_MAX) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_done_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (!tx_en_q && tx_busy) begin
      tx_state_d = TX_IDLE;
      tx_d       = 1'b1;
    end
    if (tx_rst) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      tx_d       = 1'b1;
      tx_done_d  = 1'b0;
    end
  end

  uart_rx #(
    .DW  (DW),
    .CPB (CPB)
  ) u_rx (
    .clk_i  (PCLK),
    .rst_i  (PRESETn),
    .en_i   (rx_en_q),
    .clr_i  (rx_rst),
    .rd_i   (rx_rd),
    .rx_i   (rx),
    .data_o (rx_data),
    .done_o (rx_done),
    .ferr_o (rx_ferr),
    .ovr_o  (rx_ovr)
  );

  // combinational read mux, zero outside read selects
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (idx)
        REG_CTRL:   PRDATA = {30'd0, rx_en_q, tx_en_q};
        REG_STATUS: PRDATA = {27'd0, rx_ovr, rx_ferr,
                              tx_done_q, tx_busy, rx_done};
        REG_TXDATA: PRDATA = 32'(txdata_q);
        REG_RXDATA: PRDATA = 32'(rx_data);
        default:    PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart.sv
// apb_uart directed testbench
// reset, loopback, tx waveform, disabled tx, overrun, frame error
module tb_apb_uart;

  localparam int CPB = 100;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        rx, tx;
  logic        loop_en;
  logic        rx_drv;

  int checks = 0;
  int errors = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 PCLK = ~PCLK;

  apb_uart dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .rx      (rx),
    .tx      (tx)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge; commit edge falls inside; returns at negedge
  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = 32'(a); PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
    PADDR = 32'(a);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge PCLK);
    end
    rx_drv = stop;
    repeat (CPB) @(negedge PCLK);
    rx_drv = 1'b1;
    repeat (20) @(negedge PCLK);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  pat;
    logic [9:0]  frame;
    int          n;
    int          tx_bad;

    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b0;
    @(negedge PCLK);

    // reset state
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_pready", 32'(PREADY), 32'd1);
    chk("rst_prdata_idle", PRDATA, 32'd0);
    apb_read(5'd0, d); chk("rst_ctrl", d, 32'd0);
    apb_read(5'd1, d); chk("rst_status", d, 32'd0);
    apb_read(5'd2, d); chk("rst_txdata", d, 32'd0);
    apb_read(5'd3, d); chk("rst_rxdata", d, 32'd0);
    apb_write(5'd7, 32'hFF);
    apb_read(5'd7, d); chk("unmapped", d, 32'd0);
    apb_read(5'd0, d); chk("unmapped_wr_ignored", d, 32'd0);

    // loopback
    loop_en = 1'b1;
    apb_write(5'd0, 32'hC);
    apb_write(5'd0, 32'h3);
    apb_read(5'd0, d); chk("ctrl_rw", d, 32'h3);
    apb_write(5'd2, 32'hA5);
    n = 0;
    d = '0;
    while (!d[0] && n < 1100) begin
      apb_read(5'd1, d);
      n += 2;
    end
    chk("lb_rx_done_in_time", 32'(d[0]), 32'd1);
    chk("lb_rx_before_tx", 32'(d[2:1]), 32'b01);
    apb_read(5'd2, d); chk("lb_txdata", d, 32'hA5);
    apb_read(5'd3, d); chk("lb_rxdata", d, 32'hA5);
    apb_read(5'd1, d); chk("lb_rx_done_clr", 32'(d[0]), 32'd0);
    loop_en = 1'b0;
    rx_drv = 1'b1;
    repeat (100) @(negedge PCLK);
    apb_read(5'd1, d); chk("lb_tx_done", 32'(d[2:1]), 32'b10);

    // tx waveform for 0x3C, i = edges since commit
    pat = 8'h3C;
    frame = {1'b1, pat, 1'b0};
    apb_write(5'd2, 32'(pat));
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
    PADDR = 32'd1;
    for (int i = 0; i <= 1000; i++) begin
      if (i > 0) @(negedge PCLK);
      if (i % CPB == 50) chk($sformatf("txw_bit%0d", i / CPB),
                             32'(tx), 32'(frame[i / CPB]));
      if (i == 999) chk("txw_busy_999", PRDATA[2:1], 2'b01);
      if (i == 1000) chk("txw_done_1000", PRDATA[2:1], 2'b10);
    end
    PSEL = 1'b0;
    @(negedge PCLK);
    chk("txw_idle_high", 32'(tx), 32'd1);

    // tx disabled: byte stored, no frame
    apb_write(5'd0, 32'h2);
    apb_write(5'd2, 32'h11);
    tx_bad = 0;
    repeat (300) begin
      @(negedge PCLK);
      if (tx !== 1'b1) tx_bad++;
    end
    chk("txdis_tx_high", 32'(tx_bad), 32'd0);
    apb_read(5'd1, d); chk("txdis_status", d, 32'd0);
    apb_read(5'd2, d); chk("txdis_txdata", d, 32'h11);

    // overrun
    send(8'h55, 1'b1);
    apb_read(5'd1, d); chk("ovr_first_done", d, 32'h01);
    send(8'hAA, 1'b1);
    apb_read(5'd1, d); chk("ovr_status", d, 32'h11);
    apb_read(5'd3, d); chk("ovr_rxdata", d, 32'hAA);
    apb_read(5'd1, d); chk("ovr_sticky", d, 32'h10);

    // frame error, then rx_rst
    apb_write(5'd0, 32'hA);
    apb_read(5'd1, d); chk("rxrst_status", d, 32'd0);
    send(8'h5A, 1'b0);
    apb_read(5'd1, d); chk("ferr_status", d, 32'h09);
    apb_read(5'd0, d); chk("ctrl_pulses_read0", d, 32'h2);
    apb_write(5'd0, 32'hA);
    apb_read(5'd1, d); chk("ferr_cleared", d, 32'd0);
    apb_read(5'd3, d); chk("rxdata_cleared", d, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_uart.md
# apb_uart

APB-slave UART peripheral: a 4-register APB interface in front of a fixed 8N1 transmitter and receiver running off the bus clock. It sits on the peripheral APB bus and drives or samples the off-chip `tx`/`rx` pins. Software configures enables and resets through a control register, writes bytes to transmit, polls status and reads received bytes.

## Interface
- `DATAWIDTH`, default 8: character width in bits; the frame is 1 start bit, DATAWIDTH data bits, 1 stop bit.
- `CLK_FREQ`, default 100_000_000: PCLK frequency in Hz.
- `BAUD_RATE`, default 1_000_000: line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division, minimum 4.
- `PCLK` in 1: the single clock; all logic is on its rising edge.
- `PRESETn` in 1: reset, synchronous and active-high. Reset is asserted when PRESETn=1 at a PCLK edge.
- `PADDR` in 32: register index; only PADDR[4:0] is decoded.
- `PSEL`, `PENABLE`, `PWRITE` in 1 each: APB control signals.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied to 1, so there are no wait states.
- `rx` in 1: serial input, asynchronous to PCLK.
- `tx` out 1: serial output, idles high.

## Operation
- A write commits on the edge where PSEL&PENABLE&PWRITE are all high.
- PRDATA is combinational whenever PSEL&!PWRITE. Otherwise it is 0.
- Unmapped indices read as 0, and writes to them are ignored.
- 0x00 CTRL:
  - bit0 tx_en and bit1 rx_en are read/write.
  - bit2 tx_rst and bit3 rx_rst are write-1 pulses that always read 0.
  - tx_rst returns the transmitter to idle, drives tx=1 and clears tx_busy/tx_done.
  - rx_rst returns the receiver to idle and clears rx_done, frame_err, overrun and RXDATA.
- 0x01 STATUS, read-only:
  - bit0 rx_done: sticky; cleared by reading RXDATA.
  - bit1 tx_busy.
  - bit2 tx_done: sticky; cleared by the next TXDATA write.
  - bit3 frame_err: the stop bit was sampled 0.
  - bit4 overrun: a new byte completed while rx_done was still 1.
- 0x02 TXDATA: a write stores PWDATA[7:0], which reads back.
  - If tx_en=1 and the transmitter is idle, the write starts a frame.
  - If busy or disabled, the byte is stored but no frame starts.
- 0x03 RXDATA: returns the last received byte, zero-extended.
- TX FSM states are IDLE, START, DATA and STOP. Data is sent LSB first, each bit for CLKS_PER_BIT cycles. Clearing tx_en mid-frame aborts the frame and returns tx to 1.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - In IDLE with rx_en=1, a falling edge moves the FSM to START. The input is re-sampled at CLKS_PER_BIT/2; if it is high, this is a false start and the FSM returns to IDLE.
  - Each data bit is then sampled every CLKS_PER_BIT at mid-bit, followed by the stop bit.
  - On the stop sample: RXDATA is loaded, rx_done is set, frame_err = !stop, and overrun is set if rx_done was already 1. The new byte overwrites RXDATA.
- rx_en=0 holds the receiver in IDLE.
- A same-cycle TXDATA write and tx_rst: the reset wins and no frame starts.
- A same-cycle RXDATA read and frame completion: rx_done stays 1 and RXDATA holds the new byte.

## Timing
- Reset values:
  - tx=1, PREADY=1, PRDATA=0.
  - All registers and status bits are 0.
  - Both FSMs are IDLE.
- TX latency: tx goes low on the edge following the TXDATA write commit. tx_busy is 1 from that edge.
- A full TX frame lasts 10*CLKS_PER_BIT cycles. tx_busy drops and tx_done sets at the end of the stop bit.
- RX completion: rx_done sets 1 cycle after the mid-stop-bit sample. That is about 2 + 9.5*CLKS_PER_BIT cycles after the start edge reaches the rx pin.
- With loopback (rx tied to tx), rx_done rises before tx_done.
- A reset mid-frame aborts immediately.

## Structure
- Package `apb_uart_pkg` holds:
  - register index constants (CTRL=0, STATUS=1, TXDATA=2, RXDATA=3);
  - CTRL and STATUS bit positions;
  - TX and RX state enums.
- A natural sub-module is `uart_rx`, containing the synchronizer, RX FSM and bit counter. The APB register file and the TX FSM stay in the top level.

## Test plan
- Reset, then read all four registers: every register reads 0, tx=1 and PREADY=1.
- Loopback test:
  - Write CTRL=0xC, then CTRL=0x3, then TXDATA=0xA5.
  - Poll STATUS until bit0 is set; the poll completes within 1100 cycles.
  - TXDATA reads 0xA5. RXDATA reads 0xA5.
  - After the RXDATA read, STATUS bit0 = 0.
- TX waveform, with CLKS_PER_BIT=100: write TXDATA=0x3C.
  - tx is low for 100 cycles, then carries bits 0,0,1,1,1,1,0,0, then is high.
  - tx_done sets at cycle 1000.
- Write TXDATA=0x11 with tx_en=0: tx stays 1 and tx_busy stays 0. TXDATA reads 0x11.
- Inject two frames, 0x55 then 0xAA, without reading in between: overrun=1 and RXDATA=0xAA.
- Inject a frame with the stop bit low: frame_err=1 and rx_done=1. A subsequent rx_rst clears both.
